// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the memory responder and its storage array.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lc3b_memresp_state;

    localparam int LC3B_MEMRESP_MAX_LATENCY = 15;

endpackage

// File: rtl/lc3b_mem_array.sv
// Byte-lane storage: two 8-bit banks sharing a word address, per-lane synchronous write,
// combinational word read. Contents are never reset.
module lc3b_mem_array
    import lc3b_types::*;
#(
    parameter int WORD_BITS = 7
) (
    input  logic                 clk,
    input  lc3b_mem_wmask        we,
    input  logic [WORD_BITS-1:0] waddr,
    input  lc3b_word             wdata,
    input  logic [WORD_BITS-1:0] raddr,
    output lc3b_word             rdata
);

    localparam int DEPTH = 1 << WORD_BITS;

    logic [7:0] lo_r [DEPTH];
    logic [7:0] hi_r [DEPTH];

    // lane-masked write; a cleared lane keeps its byte
    always_ff @(posedge clk) begin
        if (we[0]) begin
            lo_r[waddr] <= wdata[7:0];
        end
        if (we[1]) begin
            hi_r[waddr] <= wdata[15:8];
        end
    end

    assign rdata = {hi_r[raddr], lo_r[raddr]};

endmodule

// File: rtl/lc3b_mem_responder.sv
// Slave end of the LC-3b memory handshake: latches a request, waits LATENCY cycles,
// pulses mem_resp for one cycle and commits writes on the edge leaving RESP.
module lc3b_mem_responder
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_mem_wmask mem_byte_enable,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    output logic          mem_resp,
    output lc3b_word      mem_rdata,
    output logic          busy,
    output logic          proto_err
);

    localparam int         WB       = ADDR_BITS - 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    lc3b_memresp_state state_r, state_s;
    logic [3:0]        cnt_r, cnt_s;
    logic [WB-1:0]     addr_r;
    lc3b_word          wdata_r;
    lc3b_mem_wmask     mask_r;
    logic              is_write_r;
    logic              resp_r;
    lc3b_word          rdata_r;
    logic              busy_r;
    logic              proto_err_r;

    logic              req_s;
    logic              accept_s;
    logic              write_op_s;
    logic [WB-1:0]     rd_addr_s;
    lc3b_word          rd_word_s;
    lc3b_mem_wmask     we_s;
    logic              unused_s;

    assign req_s      = mem_read | mem_write;
    assign accept_s   = (state_r == IDLE) && req_s;
    // with LATENCY=1 RESP is entered on the accepting edge, before the latches are loaded
    assign write_op_s = accept_s ? mem_write : is_write_r;
    assign rd_addr_s  = accept_s ? mem_address[ADDR_BITS-1:1] : addr_r;
    assign unused_s   = ^{mem_address[15:ADDR_BITS], mem_address[0]};

    // next-state and latency counter
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    cnt_s   = CNT_LOAD;
                    state_s = (LATENCY == 1) ? RESP : WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (!req_s) begin
                    state_s = IDLE;
                end else if (cnt_r <= 4'd1) begin
                    cnt_s   = 4'd0;
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // storage write enable, suppressed under reset so an aborted access never commits
    always_comb begin
        if ((state_r == RESP) && is_write_r && !rst) begin
            we_s = mask_r;
        end else begin
            we_s = 2'b00;
        end
    end

    // state, request latches and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            addr_r      <= '0;
            wdata_r     <= 16'h0000;
            mask_r      <= 2'b00;
            is_write_r  <= 1'b0;
            resp_r      <= 1'b0;
            rdata_r     <= 16'h0000;
            busy_r      <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            resp_r  <= (state_s == RESP);
            busy_r  <= (state_s != IDLE);
            if (accept_s) begin
                addr_r     <= mem_address[ADDR_BITS-1:1];
                wdata_r    <= mem_wdata;
                mask_r     <= mem_byte_enable;
                is_write_r <= mem_write;
                if (mem_read && mem_write) begin
                    proto_err_r <= 1'b1;
                end
            end
            if ((state_s == RESP) && !write_op_s) begin
                rdata_r <= rd_word_s;
            end
        end
    end

    lc3b_mem_array #(
        .WORD_BITS(WB)
    ) u_array (
        .clk  (clk),
        .we   (we_s),
        .waddr(addr_r),
        .wdata(wdata_r),
        .raddr(rd_addr_s),
        .rdata(rd_word_s)
    );

    assign mem_resp  = resp_r;
    assign mem_rdata = rdata_r;
    assign busy      = busy_r;
    assign proto_err = proto_err_r;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Scoreboard bench for lc3b_mem_responder: LATENCY=3 instance for function checks,
// LATENCY=1 instance for back-to-back pulse spacing.
module tb_lc3b_mem_responder;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          mem_read = 1'b0, mem_write = 1'b0;
    lc3b_mem_wmask mem_byte_enable = 2'b00;
    lc3b_word      mem_address = 16'h0000, mem_wdata = 16'h0000;
    logic          mem_resp, busy, proto_err;
    lc3b_word      mem_rdata;

    logic          read1 = 1'b0;
    logic          resp1, busy1, perr1;
    lc3b_word      rdata1;

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(3)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .busy(busy), .proto_err(proto_err)
    );

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mem_read(read1), .mem_write(1'b0),
        .mem_byte_enable(2'b11), .mem_address(16'h0000),
        .mem_wdata(16'h0000), .mem_resp(resp1), .mem_rdata(rdata1),
        .busy(busy1), .proto_err(perr1)
    );

    typedef struct {
        bit       chk_data;
        lc3b_word data;
        int       acc;
    } sb_t;

    sb_t sbq[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every mem_resp must match the oldest outstanding request
    always @(negedge clk) begin
        if (mem_resp === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got resp=1 expected none (cycle %0d)", cyc);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("resp_latency", 32'(cyc - e.acc + 1), 32'd3);
                if (e.chk_data) chk("rdata", 32'(mem_rdata), 32'(e.data));
            end
        end
    end

    task automatic access(input bit rd, input bit wr, input lc3b_word a, input lc3b_word d,
                          input lc3b_mem_wmask m, input lc3b_word exp);
        sb_t e;
        int  n;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = d; mem_byte_enable = m;
        e.chk_data = rd && !wr;
        e.data     = exp;
        e.acc      = cyc + 1;
        sbq.push_back(e);
        @(posedge clk); #1;
        chk("busy_in_wait", 32'(busy), 32'd1);
        n = 0;
        while (mem_resp !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("resp_timeout", 32'(mem_resp), 32'd1);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        int n;
        int last;
        int pulses;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_resp", 32'(mem_resp), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_perr", 32'(proto_err), 32'd0);
        chk("reset_rdata", 32'(mem_rdata), 32'h0000);

        access(0, 1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000);
        access(1, 0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF);

        access(0, 1, 16'h0020, 16'h1234, 2'b11, 16'h0000);
        access(0, 1, 16'h0020, 16'hAB00, 2'b10, 16'h0000);
        access(1, 0, 16'h0020, 16'h0000, 2'b11, 16'hAB34);
        access(0, 1, 16'h0020, 16'h00CD, 2'b01, 16'h0000);
        chk("rdata_hold", 32'(mem_rdata), 32'hAB34);
        access(1, 0, 16'h0020, 16'h0000, 2'b00, 16'hABCD);

        access(0, 1, 16'h0104, 16'h5A5A, 2'b11, 16'h0000);
        access(1, 0, 16'h0004, 16'h0000, 2'b00, 16'h5A5A);
        access(1, 0, 16'h0005, 16'h0000, 2'b00, 16'h5A5A);

        access(0, 1, 16'h0010, 16'h0000, 2'b00, 16'h0000);
        access(1, 0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF);

        // abandon a write while it waits
        @(posedge clk); #1;
        mem_write = 1'b1; mem_address = 16'h0010; mem_wdata = 16'h1111; mem_byte_enable = 2'b11;
        @(posedge clk); #1;
        chk("abandon_busy_hi", 32'(busy), 32'd1);
        mem_write = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("abandon_busy_lo", 32'(busy), 32'd0);
        access(1, 0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF);

        // read+write conflict behaves as a write and sets the sticky flag
        access(1, 1, 16'h0030, 16'hC0DE, 2'b11, 16'h0000);
        chk("perr_set", 32'(proto_err), 32'd1);
        access(1, 0, 16'h0030, 16'h0000, 2'b00, 16'hC0DE);
        chk("perr_sticky", 32'(proto_err), 32'd1);

        // reset in the middle of a write
        @(posedge clk); #1;
        mem_write = 1'b1; mem_address = 16'h0010; mem_wdata = 16'h7777; mem_byte_enable = 2'b11;
        @(posedge clk); #1;
        chk("rst_busy_hi", 32'(busy), 32'd1);
        rst = 1'b1; mem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_resp", 32'(mem_resp), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_perr", 32'(proto_err), 32'd0);
        chk("midrst_rdata", 32'(mem_rdata), 32'h0000);
        repeat (4) @(posedge clk);
        access(1, 0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF);

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        // LATENCY=1 with mem_read held: one pulse every two cycles
        @(posedge clk); #1;
        read1 = 1'b1;
        last = -1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp1 === 1'b1) begin
                if (last >= 0) chk("b2b_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                pulses++;
            end
        end
        read1 = 1'b0;
        chk("b2b_pulses", 32'(pulses), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
